// File: rtl/mic_sample_reader.sv
// Microphone ADC reader: each rising edge of sample_clk starts one SPI read frame
// (CS low, FRAME_BITS SCLK rises, MSB first) and publishes the low DATA_BITS bits.
module mic_sample_reader #(
  parameter int SCLK_HALF  = 50,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_clk,
  input  logic                 mic_miso,
  output logic                 mic_cs_n,
  output logic                 mic_sclk,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_HALF - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(FRAME_BITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, QUIET} state_t;

  state_t               state;
  logic [2:0]           sync;      // [1:0] synchroniser, [2] previous synchronised level
  logic                 trig;
  logic [CW-1:0]        half_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg; // leading frame bits fall off the top unchecked

  assign trig = sync[1] & ~sync[2];

  // NOTE: every register here is updated with <= so all reads in a cycle see
  // the pre-edge values; blocking assignments would make the order of lines matter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      sync         <= '0;
      half_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      mic_cs_n     <= 1'b1;
      mic_sclk     <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sync         <= {sync[1:0], sample_clk};
      sample_valid <= 1'b0;
      if (trig && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (trig) begin
            state    <= SETUP;
            mic_cs_n <= 1'b0;
            busy     <= 1'b1;
            half_cnt <= '0;
          end
        end
        SETUP: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            mic_sclk <= 1'b0;
            state    <= SHIFT;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (!mic_sclk) begin
              // Rising SCLK: the ADC drove this bit after the previous fall.
              mic_sclk  <= 1'b1;
              shift_reg <= {shift_reg[DATA_BITS-2:0], mic_miso};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == BITS_LAST) begin
                mic_cs_n <= 1'b1;
                state    <= DONE;
              end
            end else begin
              mic_sclk <= 1'b0;
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        DONE: begin
          sample       <= shift_reg;
          sample_valid <= 1'b1;
          half_cnt     <= '0;
          state        <= QUIET;
        end
        QUIET: begin
          if (half_cnt == HALF_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
